// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: channel mode encodings
// and a helper that pulls one channel's field out of a flattened configuration bus.
package pwm_pkg;

  typedef enum logic [1:0] {
    PWM_LEFT   = 2'b00,
    PWM_RIGHT  = 2'b01,
    PWM_WINDOW = 2'b10,
    PWM_CENTER = 2'b11
  } pwm_mode_e;

  localparam int SLICE_BUS_W = 1024;
  localparam int SLICE_MAX_W = 64;

  // Returns field idx of the given width; callers cast the result to the field width.
  function automatic logic [SLICE_MAX_W-1:0] get_slice(
    input logic [SLICE_BUS_W-1:0] bus,
    input int                     idx,
    input int                     width
  );
    logic [SLICE_MAX_W-1:0] mask;
    mask = (SLICE_MAX_W'(1) << width) - SLICE_MAX_W'(1);
    return SLICE_MAX_W'(bus >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/pwm_chan_cmp.sv
// One PWM channel: shadowed mode/polarity/compare registers, the mode-dependent
// level compare against the shared counter, and the registered output.
module pwm_chan_cmp
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_polarity,
  input  logic [CNT_W-1:0] cfg_compare1,
  input  logic [CNT_W-1:0] cfg_compare2,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] period,
  output logic             pwm_out
);

  localparam int XW = CNT_W + 1;

  pwm_mode_e        mode_reg;
  logic             pol_reg;
  logic [CNT_W-1:0] cmp1_reg;
  logic [CNT_W-1:0] cmp2_reg;

  logic [XW-1:0] cnt_x;
  logic [XW-1:0] cmp1_x;
  logic [XW-1:0] cmp2_x;
  logic [XW-1:0] span_x;
  logic [XW-1:0] center_hi;
  logic          raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= PWM_LEFT;
      pol_reg  <= 1'b0;
      cmp1_reg <= '0;
      cmp2_reg <= '0;
    end else if (load) begin
      mode_reg <= pwm_mode_e'(cfg_mode);
      pol_reg  <= cfg_polarity;
      cmp1_reg <= cfg_compare1;
      cmp2_reg <= cfg_compare2;
    end
  end

  // One extra bit so period+1 and the center upper bound never wrap.
  always_comb begin
    cnt_x     = {1'b0, count};
    cmp1_x    = {1'b0, cmp1_reg};
    cmp2_x    = {1'b0, cmp2_reg};
    span_x    = {1'b0, period} + XW'(1);
    center_hi = span_x - cmp1_x;
    raw       = 1'b0;
    case (mode_reg)
      PWM_LEFT:   raw = (cnt_x < cmp1_x);
      PWM_RIGHT:  raw = (cnt_x >= cmp1_x);
      PWM_WINDOW: raw = (cnt_x >= cmp1_x) && (cnt_x < cmp2_x);
      PWM_CENTER: raw = (cmp1_x <= span_x) && (cnt_x >= cmp1_x) && (cnt_x < center_hi);
      default:    raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else if (en) begin
      pwm_out <= raw ^ pol_reg;
    end
  end

endmodule

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: prescaled shared period counter with double-buffered
// configuration that only switches at a period boundary.
module pwm_gen_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pwm_en,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [PRESC_W-1:0]      cfg_prescale,
  input  logic [2*NUM_CH-1:0]     cfg_mode,
  input  logic [NUM_CH-1:0]       cfg_polarity,
  input  logic [CNT_W*NUM_CH-1:0] cfg_compare1,
  input  logic [CNT_W*NUM_CH-1:0] cfg_compare2,
  input  logic                    cfg_update,
  output logic [CNT_W-1:0]        count_val,
  output logic                    period_tick,
  output logic                    update_pending,
  output logic [NUM_CH-1:0]       pwm_out
);

  logic [PRESC_W-1:0] presc_cnt_reg;
  logic [PRESC_W-1:0] act_prescale_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   act_period_reg;
  logic               update_pending_reg;

  logic tick;
  logic at_top;
  logic swap_now;
  logic load_active;

  assign tick        = (presc_cnt_reg == act_prescale_reg);
  assign at_top      = (count_reg == act_period_reg);
  assign period_tick = pwm_en & tick & at_top;
  assign swap_now    = period_tick & (update_pending_reg | cfg_update);
  // While disabled the shadow set tracks the inputs so enabling starts from fresh values.
  assign load_active = ~pwm_en | swap_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_reg      <= '0;
      count_reg          <= '0;
      update_pending_reg <= 1'b0;
    end else if (!pwm_en) begin
      presc_cnt_reg      <= '0;
      count_reg          <= '0;
      update_pending_reg <= 1'b0;
    end else begin
      if (tick) begin
        presc_cnt_reg <= '0;
        count_reg     <= at_top ? '0 : count_reg + CNT_W'(1);
      end else begin
        presc_cnt_reg <= presc_cnt_reg + PRESC_W'(1);
      end
      if (swap_now) begin
        update_pending_reg <= 1'b0;
      end else if (cfg_update) begin
        update_pending_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_period_reg   <= '0;
      act_prescale_reg <= '0;
    end else if (load_active) begin
      act_period_reg   <= cfg_period;
      act_prescale_reg <= cfg_prescale;
    end
  end

  assign count_val      = count_reg;
  assign update_pending = update_pending_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]       ch_mode;
    logic [CNT_W-1:0] ch_cmp1;
    logic [CNT_W-1:0] ch_cmp2;

    assign ch_mode = 2'(get_slice(SLICE_BUS_W'(cfg_mode), gi, 2));
    assign ch_cmp1 = CNT_W'(get_slice(SLICE_BUS_W'(cfg_compare1), gi, CNT_W));
    assign ch_cmp2 = CNT_W'(get_slice(SLICE_BUS_W'(cfg_compare2), gi, CNT_W));

    pwm_chan_cmp #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (pwm_en),
      .load         (load_active),
      .cfg_mode     (ch_mode),
      .cfg_polarity (cfg_polarity[gi]),
      .cfg_compare1 (ch_cmp1),
      .cfg_compare2 (ch_cmp2),
      .count        (count_reg),
      .period       (act_period_reg),
      .pwm_out      (pwm_out[gi])
    );
  end

endmodule

// File: doc/pwm_gen_multi.md
Name: pwm_gen_multi

Overview:
- Multi-channel successor of the single-channel PWM generator, with its own prescaled period counter.
- Drives NUM_CH PWM outputs from one shared time base. Each channel has its own alignment mode, compare values and output polarity.
- Configuration is double-buffered: new values take effect only at a period boundary, so no glitched or runt pulses are produced.
- Sits between the register file (cfg_* inputs) and the top-level pins.

Parameters:
- NUM_CH, 4, number of PWM channels.
- CNT_W, 16, width of the period counter and of the period/compare values.
- PRESC_W, 8, width of the clock prescaler.

Ports:
- clk  in  1  peripheral clock.
- rst_n  in  1  reset; asynchronous, active-low.
- pwm_en  in  1  global enable for counter and outputs.
- cfg_period  in  CNT_W  last count value of a period; the period lasts cfg_period+1 counter ticks.
- cfg_prescale  in  PRESC_W  counter advances once every cfg_prescale+1 clk cycles.
- cfg_mode  in  2*NUM_CH  per-channel mode, channel i at bits [2i+1:2i].
- cfg_polarity  in  NUM_CH  1 = invert that channel's output.
- cfg_compare1  in  CNT_W*NUM_CH  per-channel compare1, channel i at slice i.
- cfg_compare2  in  CNT_W*NUM_CH  per-channel compare2, channel i at slice i.
- cfg_update  in  1  one-cycle pulse requesting a shadow load.
- count_val  out  CNT_W  current counter value.
- period_tick  out  1  high in the cycle the counter wraps.
- update_pending  out  1  a shadow load is armed.
- pwm_out  out  NUM_CH  PWM outputs.

Behaviour:
- Reset values: counter 0, prescaler 0, update_pending 0, pwm_out all 0. Active (shadow) set is loaded from the cfg_* inputs on the first enabled-low cycle after reset.
- Active set: period, prescale, modes, polarity, compare1/2 registers. Compare logic uses only the active set, never cfg_* directly.
- pwm_en=0:
  - counter held at 0 and prescaler held at 0.
  - active set loaded from cfg_* every cycle; update_pending cleared.
  - pwm_out holds its last value.
- pwm_en=1:
  - tick = (presc_cnt == active prescale). On tick, presc_cnt goes to 0; otherwise presc_cnt increments.
  - On tick, the counter goes to 0 if count_val == active period; otherwise it increments.
  - period_tick = pwm_en & tick & (count_val == active period). It is combinational from registers and lasts one cycle.
- Shadow load:
  - A cfg_update pulse sets update_pending.
  - At the clock edge where period_tick=1 and update_pending=1 (or cfg_update=1 in that same cycle), the active set is loaded from cfg_* and update_pending clears. The new values apply starting at count 0.
  - A cfg_update while already pending has no additional effect.
- Per-channel raw level, compared against count_val and using CNT_W+1 bit arithmetic:
  - 00 left-aligned: cnt < cmp1.
  - 01 right-aligned: cnt >= cmp1.
  - 10 window: cmp1 <= cnt < cmp2.
  - 11 center-symmetric: cmp1 <= cnt < (period+1-cmp1). This term must not underflow; if cmp1 > period+1 the output is low.
- pwm_out[i] <= raw[i] ^ polarity[i], registered. Latency is 1 clk from count_val.
- Boundary cases:
  - period=0: counter stays 0 and period_tick pulses every prescaled tick.
  - Left mode, cmp1=0: always low.
  - Left mode, cmp1 > period: always high.
  - Window mode, cmp2 <= cmp1: always low.
  - Center mode, 2*cmp1 >= period+1: always low.
  - Changing cfg_* without cfg_update never affects the outputs while enabled.
- Reset asserted mid-period: everything returns to reset values immediately (asynchronous). After release, the block waits for pwm_en before counting.
- 0->1 transition of pwm_en: counting starts at 0, using the active set captured while disabled.

Decomposition:
- Package pwm_pkg:
  - mode encodings PWM_LEFT=2'b00, PWM_RIGHT=2'b01, PWM_WINDOW=2'b10, PWM_CENTER=2'b11.
  - a function extracting channel slices from the flattened buses.
- Sub-module pwm_chan_cmp, generated NUM_CH times. It contains the per-channel shadow registers, the mode compare and the output flop.
- The counter, prescaler and update control stay in the top module.

Test Plan:
- Reset, then pwm_en=1, period=9, prescale=0, ch0 mode 00, cmp1=3 -> count_val 0..9 repeating; pwm_out[0] high for 3 of every 10 cycles, lagging count by 1 clk; period_tick pulses every 10 cycles.
- prescale=3, period=4, ch1 mode 01, cmp1=2 -> count advances every 4 clk; pwm_out[1] high for 12 of every 20 clk.
- ch2 window cmp1=2, cmp2=6, period=9, and ch3 center cmp1=2 -> ch2 high at counts 2..5; ch3 high at counts 2..7. Then set polarity[3]=1 with an update -> ch3 is inverted from the next period onward.
- Mid-period: change cmp1 3->7 and pulse cfg_update at count 4 -> update_pending=1; duty stays 3 until the wrap, becomes 7 from count 0; update_pending clears at the wrap.
- Edge values: cmp1=0 left -> constant 0; cmp1=12 with period=9 -> constant 1; cmp2=cmp1 window -> constant 0; period=0 -> period_tick every tick.
- Assert rst_n low at count 5 -> pwm_out=0, count_val=0 and update_pending=0 immediately. Drop pwm_en mid-high -> pwm_out holds 1 and the counter is held at 0.
